// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, plus an iterative shift-add
// multiply that keeps the block busy for W cycles. All results and flags are registered.
module alu_seq #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [SW-1:0] sham,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  sum,
  output logic          zout,
  output logic          nout,
  output logic          cout,
  output logic          vout,
  output logic          err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  localparam logic [SW:0] CNT_INIT = (SW+1)'(W);
  localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           vout_q;
  logic           err_q;
  logic           outValid_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [SW:0]    cnt_q;

  logic           accept;
  logic [W:0]     addRes;
  logic [W:0]     subRes;
  logic           addOvf;
  logic           subOvf;
  logic [W-1:0]   res_d;
  logic           cout_d;
  logic           vout_d;
  logic           err_d;
  logic [2*W-1:0] acc_d;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // SUB is a + ~b + 1 so its carry-out reads as "no borrow".
  always_comb begin
    addRes = {1'b0, a} + {1'b0, b};
    subRes = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    addOvf = (a[W-1] == b[W-1]) && (addRes[W-1] != a[W-1]);
    subOvf = (a[W-1] != b[W-1]) && (subRes[W-1] != a[W-1]);
    res_d  = '0;
    cout_d = 1'b0;
    vout_d = 1'b0;
    err_d  = 1'b0;
    case (op)
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_ADD: begin
        res_d  = addRes[W-1:0];
        cout_d = addRes[W];
        vout_d = addOvf;
      end
      OP_SUB: begin
        res_d  = subRes[W-1:0];
        cout_d = subRes[W];
        vout_d = subOvf;
      end
      OP_SLT: res_d = {{(W-1){1'b0}}, subRes[W-1] ^ subOvf};
      OP_SRL: res_d = b >> sham;
      OP_SLL: res_d = b << sham;
      OP_SRA: res_d = $signed(b) >>> sham;
      OP_MUL: res_d = '0;
      default: err_d = 1'b1;
    endcase
  end

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The last multiply iteration writes its accumulator straight into the result
  // registers so out_valid rises exactly W edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      vout_q     <= 1'b0;
      err_q      <= 1'b0;
      outValid_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        sum_q      <= acc_d[W-1:0];
        cout_q     <= |acc_d[2*W-1:W];
        vout_q     <= 1'b0;
        err_q      <= 1'b0;
        outValid_q <= 1'b1;
        state_q    <= S_DONE;
      end
    end else if (accept) begin
      if (op == OP_MUL) begin
        acc_q      <= '0;
        mcand_q    <= {{W{1'b0}}, a};
        mplier_q   <= b;
        cnt_q      <= CNT_INIT;
        outValid_q <= 1'b0;
        state_q    <= S_MUL;
      end else begin
        sum_q      <= res_d;
        cout_q     <= cout_d;
        vout_q     <= vout_d;
        err_q      <= err_d;
        outValid_q <= 1'b1;
        state_q    <= S_DONE;
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      outValid_q <= 1'b0;
      state_q    <= S_IDLE;
    end
  end

  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign zout      = (sum_q == '0);
  assign nout      = sum_q[W-1];
  assign cout      = cout_q;
  assign vout      = vout_q;
  assign err       = err_q;

endmodule
